// File: rtl/console_pkg.sv
// Shared geometry, control codes and enums for the text console writer.
// Used by both builds; CONSOLE_SCROLL_EN only affects the modules that import this package.
package console_pkg;

   localparam int unsigned COLS       = 80;
   localparam int unsigned ROWS       = 60;
   localparam int unsigned CELLS      = 4800;
   localparam int unsigned SCROLL_LEN = 4720;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned ROW_W  = 6;
   localparam int unsigned COL_W  = 7;
   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] BLANK   = 8'h20;
   localparam logic [DATA_W-1:0] CODE_BS = 8'h08;
   localparam logic [DATA_W-1:0] CODE_LF = 8'h0A;
   localparam logic [DATA_W-1:0] CODE_FF = 8'h0C;
   localparam logic [DATA_W-1:0] CODE_CR = 8'h0D;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      SCROLL = 2'd2,
      CLRROW = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CUR_NONE = 3'd0,
      CUR_INC  = 3'd1,
      CUR_CR   = 3'd2,
      CUR_LF   = 3'd3,
      CUR_BS   = 3'd4,
      CUR_HOME = 3'd5
   } cursor_op_t;

   function automatic logic is_printable(input logic [DATA_W-1:0] code);
      return !(code == CODE_BS || code == CODE_LF || code == CODE_FF || code == CODE_CR);
   endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor tracker: row/col plus linear cell address, updated by one op per cycle.
// CONSOLE_SCROLL_EN: overflow parks at the last row; otherwise it wraps to row 0.
module console_cursor
   import console_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  cursor_op_t        op,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic [ADDR_W-1:0] addr,
   output logic              overflow_c
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
`ifdef CONSOLE_SCROLL_EN
   localparam logic [ROW_W-1:0]  WRAP_ROW  = LAST_ROW;
   localparam logic [ADDR_W-1:0] WRAP_BASE = ADDR_W'(SCROLL_LEN);
`else
   localparam logic [ROW_W-1:0]  WRAP_ROW  = '0;
   localparam logic [ADDR_W-1:0] WRAP_BASE = '0;
`endif

   logic [ROW_W-1:0]  row_n;
   logic [COL_W-1:0]  col_n;
   logic [ADDR_W-1:0] addr_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else begin
         row  <= row_n;
         col  <= col_n;
         addr <= addr_n;
      end
   end

   // Linear address tracks row/col incrementally so no multiplier is needed.
   always_comb begin
      row_n      = row;
      col_n      = col;
      addr_n     = addr;
      overflow_c = 1'b0;
      case (op)
         CUR_INC: begin
            if (col == LAST_COL) begin
               col_n = '0;
               if (row == LAST_ROW) begin
                  overflow_c = 1'b1;
                  row_n      = WRAP_ROW;
                  addr_n     = WRAP_BASE;
               end else begin
                  row_n  = row + ROW_W'(1);
                  addr_n = addr + ADDR_W'(1);
               end
            end else begin
               col_n  = col + COL_W'(1);
               addr_n = addr + ADDR_W'(1);
            end
         end
         CUR_CR: begin
            col_n  = '0;
            addr_n = addr - ADDR_W'(col);
         end
         CUR_LF: begin
            if (row == LAST_ROW) begin
               overflow_c = 1'b1;
               row_n      = WRAP_ROW;
               addr_n     = WRAP_BASE + ADDR_W'(col);
            end else begin
               row_n  = row + ROW_W'(1);
               addr_n = addr + ADDR_W'(COLS);
            end
         end
         CUR_BS: begin
            if (col != '0) begin
               col_n  = col - COL_W'(1);
               addr_n = addr - ADDR_W'(1);
            end
         end
         CUR_HOME: begin
            row_n  = '0;
            col_n  = '0;
            addr_n = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream console writer: glyph/colour RAM writes, control codes, clear and scroll.
// CONSOLE_SCROLL_EN: overflow copies rows up through the read port; otherwise only row 0 is blanked.
module text_console_writer
   import console_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        attr,
   output logic              busy,
   output logic              wr_en,
   output logic [12:0]       wr_addr,
   output logic [7:0]        wr_char,
   output logic [7:0]        wr_colour,
   output logic [12:0]       rd_addr,
   input  logic [7:0]        rd_char,
   input  logic [7:0]        rd_colour,
   output logic [5:0]        cursor_row,
   output logic [6:0]        cursor_col
);

   localparam logic [ADDR_W-1:0] CLEAR_END = ADDR_W'(CELLS);
`ifdef CONSOLE_SCROLL_EN
   localparam state_t            OVF_STATE  = SCROLL;
   localparam logic [ADDR_W-1:0] CLRROW_END = ADDR_W'(CELLS);
   localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'(SCROLL_LEN - 1);
`else
   localparam state_t            OVF_STATE  = CLRROW;
   localparam logic [ADDR_W-1:0] CLRROW_END = ADDR_W'(COLS);
`endif

   state_t             state, state_n;
   logic [ADDR_W-1:0]  idx, idx_n;
   logic               wr_en_n;
   logic [ADDR_W-1:0]  wr_addr_n;
   logic [DATA_W-1:0]  wr_char_q, wr_char_n;
   logic [DATA_W-1:0]  wr_colour_q, wr_colour_n;
   logic [DATA_W-1:0]  attr_q, attr_n;
   logic               accept_c;
   cursor_op_t         cur_op;
   logic [ADDR_W-1:0]  cursor_addr;
   logic               overflow_c;

   assign in_ready = (state == IDLE) && !rst;
   assign busy     = (state != IDLE);
   assign accept_c = in_valid && in_ready;

   console_cursor u_cursor (
      .clk        (clk),
      .rst        (rst),
      .op         (cur_op),
      .row        (cursor_row),
      .col        (cursor_col),
      .addr       (cursor_addr),
      .overflow_c (overflow_c)
   );

   // Control-code decode kept apart so overflow feedback does not loop through one block.
   always_comb begin
      cur_op = CUR_NONE;
      if (accept_c) begin
         if (is_printable(in_data)) begin
            cur_op = CUR_INC;
         end else begin
            case (in_data)
               CODE_CR: cur_op = CUR_CR;
               CODE_LF: cur_op = CUR_LF;
               CODE_BS: cur_op = CUR_BS;
               default: cur_op = CUR_HOME;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= state_n;
   end

   // Each bulk state spends one extra cycle at its end index so in_ready trails the last write.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (in_data == CODE_FF) state_n = CLEAR;
               else if (overflow_c)    state_n = OVF_STATE;
            end
         end
         CLEAR:  if (idx == CLEAR_END)  state_n = IDLE;
         CLRROW: if (idx == CLRROW_END) state_n = IDLE;
`ifdef CONSOLE_SCROLL_EN
         SCROLL: if (idx == COPY_LAST)  state_n = CLRROW;
`else
         SCROLL: state_n = IDLE;
`endif
         default: state_n = IDLE;
      endcase
   end

`ifdef CONSOLE_SCROLL_EN
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
   logic              copy_q, copy_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q <= '0;
         copy_q    <= 1'b0;
      end else begin
         rd_addr_q <= rd_addr_n;
         copy_q    <= copy_n;
      end
   end

   // Copy cycles pass RAM read data straight through to land one cycle after the read address.
   assign rd_addr   = rd_addr_q;
   assign wr_char   = copy_q ? rd_char   : wr_char_q;
   assign wr_colour = copy_q ? rd_colour : wr_colour_q;
`else
   logic unused_rd;
   assign unused_rd = ^{rd_char, rd_colour};
   assign rd_addr   = '0;
   assign wr_char   = wr_char_q;
   assign wr_colour = wr_colour_q;
`endif

   always_comb begin
      idx_n       = idx;
      wr_en_n     = 1'b0;
      wr_addr_n   = wr_addr;
      wr_char_n   = wr_char_q;
      wr_colour_n = wr_colour_q;
      attr_n      = attr_q;
`ifdef CONSOLE_SCROLL_EN
      copy_n      = 1'b0;
      rd_addr_n   = rd_addr_q;
`endif
      case (state)
         IDLE: begin
            if (accept_c) begin
               attr_n = attr;
               if (is_printable(in_data)) begin
                  wr_en_n     = 1'b1;
                  wr_addr_n   = cursor_addr;
                  wr_char_n   = in_data;
                  wr_colour_n = attr;
               end
               if (in_data == CODE_FF || overflow_c) idx_n = '0;
`ifdef CONSOLE_SCROLL_EN
               if (overflow_c) rd_addr_n = ADDR_W'(COLS);
`endif
            end
         end
         CLEAR: begin
            if (idx != CLEAR_END) begin
               wr_en_n     = 1'b1;
               wr_addr_n   = idx;
               wr_char_n   = BLANK;
               wr_colour_n = attr_q;
               idx_n       = idx + ADDR_W'(1);
            end
         end
         CLRROW: begin
            if (idx != CLRROW_END) begin
               wr_en_n     = 1'b1;
               wr_addr_n   = idx;
               wr_char_n   = BLANK;
               wr_colour_n = attr_q;
               idx_n       = idx + ADDR_W'(1);
            end
         end
`ifdef CONSOLE_SCROLL_EN
         SCROLL: begin
            wr_en_n   = 1'b1;
            wr_addr_n = idx;
            copy_n    = 1'b1;
            idx_n     = idx + ADDR_W'(1);
            if (idx != COPY_LAST) rd_addr_n = rd_addr_q + ADDR_W'(1);
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_char_q   <= '0;
         wr_colour_q <= '0;
         attr_q      <= '0;
      end else begin
         idx         <= idx_n;
         wr_en       <= wr_en_n;
         wr_addr     <= wr_addr_n;
         wr_char_q   <= wr_char_n;
         wr_colour_q <= wr_colour_n;
         attr_q      <= attr_n;
      end
   end

endmodule
